// File: rtl/load_store_unit_if.sv
// Request/response and data_memory signals of the load/store unit.
// slave : the load/store unit's view (accepts requests, drives the memory port).
// master: the pipeline/memory side (issues requests, supplies mem_read_data).
interface load_store_unit_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_write
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word memory with combinational
// read and posedge write. Sub-word stores are read-modify-write.
// Optional feature macro: ALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses return resp_err, no write
//   undefined -> low address bits are forced to natural alignment
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory addressed; load captured, SW written, or merge word built
// WRITE  | merged word for SH/SB written
// RESP   | one-cycle response
module load_store_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    state_t            state;
    state_t            state_nxt;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              acc_err;
    logic [1:0]        lane_off;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged_word;

    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;

    // Error detection and effective byte lane for the latched request.
    always_comb begin
        acc_err = (addr_q[31:2] >= DEPTH_IDX) || (size_q == 2'b11);
`ifdef ALIGN_CHECK_EN
        if ((size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00))
            acc_err = 1'b1;
        lane_off = addr_q[1:0];
`else
        case (size_q)
            2'b01:   lane_off = {addr_q[1], 1'b0};
            2'b10:   lane_off = 2'b00;
            default: lane_off = addr_q[1:0];
        endcase
`endif
    end

    // Lane extraction, load extension and store merge from the current read word.
    always_comb begin
        case (lane_off)
            2'd0:    lane_byte = bus.mem_read_data[7:0];
            2'd1:    lane_byte = bus.mem_read_data[15:8];
            2'd2:    lane_byte = bus.mem_read_data[23:16];
            default: lane_byte = bus.mem_read_data[31:24];
        endcase
        lane_half = lane_off[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
            default: load_ext = bus.mem_read_data;
        endcase

        merged_word = bus.mem_read_data;
        if (size_q == 2'b00) begin
            case (lane_off)
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (lane_off[1])
                merged_word[31:16] = wdata_q[15:0];
            else
                merged_word[15:0]  = wdata_q[15:0];
        end
    end

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and memory/response outputs.
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_err       = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_address = {2'b00, addr_q[31:2]};
                if (acc_err || !we_q) begin
                    state_nxt = RESP;
                end else if (size_q == 2'b10) begin
                    mem_write      = 1'b1;
                    mem_write_data = wdata_q;
                    state_nxt      = RESP;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_address    = {2'b00, addr_q[31:2]};
                mem_write      = 1'b1;
                mem_write_data = merged_q;
                state_nxt      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch on accept; load result, error and merge word captured in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end else if (state == ACCESS) begin
            err_q    <= acc_err;
            rdata_q  <= (acc_err || we_q) ? '0 : load_ext;
            merged_q <= merged_word;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_rdata     = resp_rdata;
    assign bus.resp_err       = resp_err;
    assign bus.mem_address    = mem_address;
    assign bus.mem_write_data = mem_write_data;
    assign bus.mem_write      = mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random requests,
// checked against a byte-array reference memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_clear = 1'b1;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // data_memory: combinational read, posedge write
    logic [31:0] mem [256];
    assign bus.mem_read_data = (bus.mem_address < 32'd256) ? mem[bus.mem_address[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.mem_write && bus.mem_address < 32'd256) begin
            mem[bus.mem_address[7:0]] <= bus.mem_write_data;
        end
    end

    // reference: flat little-endian byte memory
    logic [7:0] rmem [1024];

    int tests = 0;
    int fails = 0;

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          last_writes;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] e_rdata, output logic e_err,
                          output int e_lat, output int e_writes);
        int nb;
        int ea;
        logic [31:0] v;
        nb       = 1 << size;
        e_err    = (size == 2'b11) || (addr >= 32'd1024);
        e_rdata  = 32'h0;
        e_lat    = 2;
        e_writes = 0;
        ea       = 0;
        if (!e_err) begin
            ea = int'(addr);
`ifdef ALIGN_CHECK_EN
            if (ea % nb != 0) e_err = 1'b1;
`else
            ea = ea - (ea % nb);
`endif
        end
        if (!e_err) begin
            if (!we) begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v = v | (32'(rmem[ea+k]) << (8*k));
                if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e_rdata = v;
            end else begin
                for (int k = 0; k < nb; k++) rmem[ea+k] = wdata[8*k +: 8];
                e_writes = 1;
                e_lat    = (nb == 4) ? 2 : 3;
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_writes;
        int          lat;
        int          writes;
        bit          got;
        ref_op(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_writes);
        @(negedge clk);
        check("req_ready_before", bus.req_ready, 1);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat    = 1;
        writes = 0;
        got    = 0;
        while (!got && lat <= 8) begin
            if (bus.resp_valid) begin
                got = 1;
            end else begin
                if (bus.mem_write) begin
                    writes++;
                    last_waddr = bus.mem_address;
                    last_wdata = bus.mem_write_data;
                end
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check("resp_seen", 32'(got), 1);
        last_rdata  = bus.resp_rdata;
        last_err    = bus.resp_err;
        last_lat    = lat;
        last_writes = writes;
        check("latency", lat, e_lat);
        check("write_count", writes, e_writes);
        check("resp_rdata", bus.resp_rdata, e_rdata);
        check("resp_err", bus.resp_err, e_err);
        check("resp_mem_write", bus.mem_write, 0);
        @(posedge clk);
        #1;
        check("resp_one_cycle", bus.resp_valid, 0);
        if (e_writes != 0) check("mem_word", mem[addr[9:2]], ref_word(int'(addr[9:2])));
    endtask

    initial begin
        int r;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) rmem[i] = 8'h00;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        last_waddr = 32'h0;
        last_wdata = 32'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_mem_wdata", bus.mem_write_data, 0);
        mem_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_mem_write", bus.mem_write, 0);
        end

        // SW then LW at word 4
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_waddr", last_waddr, 32'd4);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_writes", last_writes, 1);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_latency", last_lat, 2);

        // SB merge
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
        check("sb_wdata", last_wdata, 32'hDEAD55EF);
        check("sb_latency", last_lat, 3);
        check("sb_mem", mem[4], 32'hDEAD55EF);

        // extension cases on 0x80FF7F01
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        run_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        check("lb_0x12", last_rdata, 32'hFFFFFFFF);
        run_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        check("lbu_0x12", last_rdata, 32'h000000FF);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("lh_0x12", last_rdata, 32'hFFFF80FF);
        run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        check("lhu_0x10", last_rdata, 32'h00007F01);

        // out of range store
        run_op(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678);
        check("oor_err", last_err, 1);
        check("oor_writes", last_writes, 0);

        // misaligned half
        run_op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
`ifdef ALIGN_CHECK_EN
        check("lh_0x11_err", last_err, 1);
        check("lh_0x11_rdata", last_rdata, 32'h0);
`else
        check("lh_0x11_err", last_err, 0);
        check("lh_0x11_rdata", last_rdata, 32'h00007F01);
`endif

        // reserved size
        run_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check("rsv_err", last_err, 1);

        // reset during ACCESS of SH 0x10
        @(negedge clk);
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'h0000A5A5;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_mem_write", bus.mem_write, 0);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_resp", bus.resp_valid, 0);
            check("abort_no_write", bus.mem_write, 0);
        end
        check("abort_word4", mem[4], 32'h80FF7F01);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h400 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom;
            else             a = $urandom_range(0, 127);
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int w = 0; w < 256; w++) check("final_mem", mem[w], ref_word(w));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
